// File: rtl/rdata_chan_mngr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rdata_chan_mngr : manager-side R-channel receiver, 4x32-bit burst -> 128-bit word
// Optional stall timeout: define RDAT_M_TIMEOUT_EN.   Rev 1.0
// ---------------------------------------------------------------------------
module rdata_chan_mngr #(
   parameter int unsigned TO_CYCLES = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           rvalid,
   output logic           rready,
   input  logic [3:0]     rid,
   input  logic [31:0]    rdata,
   input  logic           rlast,
   input  logic           rdata_m_start,
   input  logic [3:0]     rdata_m_exp_id,
   output logic           rdata_m_valid,
   output logic [127:0]   rdata_m_data,
   output logic [3:0]     rdata_m_id,
   output logic           rdata_m_err,
   input  logic           rdata_m_ack,
   output logic           rdata_m_busy
`ifdef RDAT_M_TIMEOUT_EN
   ,
   output logic           rdata_m_timeout
`endif
);

   typedef enum logic [1:0] {
      MIDLE = 2'b00,
      MRECV = 2'b01,
      MFULL = 2'b10,
      MDEFO = 2'b11
   } state_t;

   if ((TO_CYCLES < 1) || (TO_CYCLES > 65535)) begin : g_to_range_err
      $error("rdata_chan_mngr: TO_CYCLES must be within 1..65535");
   end

   state_t         state_q, state_d;
   logic [127:0]   buf_q, buf_d;
   logic [3:0]     id_q, id_d;
   logic           err_q, err_d;
   logic [1:0]     cnt_q, cnt_d;
   logic           w_beat;
   logic           w_setup;

`ifdef RDAT_M_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TO_CYCLES - 1);
   logic [15:0]    stall_q, stall_d;
   logic           to_q, to_d;
   assign rdata_m_timeout = to_q;
`endif

   assign rready        = (state_q == MRECV);
   assign rdata_m_valid = (state_q == MFULL);
   assign rdata_m_busy  = (state_q != MIDLE);
   assign rdata_m_data  = buf_q;
   assign rdata_m_id    = id_q;
   assign rdata_m_err   = err_q;

   assign w_beat  = rvalid & rready;
   // A new transaction starts from idle, or straight out of MFULL when ack and start coincide
   assign w_setup = rdata_m_start &
                    ((state_q == MIDLE) || ((state_q == MFULL) && rdata_m_ack));

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      id_d    = id_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
`ifdef RDAT_M_TIMEOUT_EN
      stall_d = stall_q;
      to_d    = to_q;
`endif
      case (state_q)
         MIDLE: begin
            if (rdata_m_start) state_d = MRECV;
         end
         MRECV: begin
            if (w_beat) begin
               buf_d[{cnt_q, 5'd0} +: 32] = rdata;
               if (rid != id_q) err_d = 1'b1;
`ifdef RDAT_M_TIMEOUT_EN
               stall_d = 16'd0;
`endif
               if (cnt_q == 2'd3) begin
                  state_d = MFULL;
                  if (!rlast) err_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 2'd1;
                  if (rlast) begin
                     state_d = MFULL;
                     err_d   = 1'b1;
                  end
               end
            end
`ifdef RDAT_M_TIMEOUT_EN
            else if (stall_q == TO_LAST) begin
               state_d = MFULL;
               err_d   = 1'b1;
               to_d    = 1'b1;
            end else begin
               stall_d = stall_q + 16'd1;
            end
`endif
         end
         MFULL: begin
            if (rdata_m_ack) begin
               state_d = rdata_m_start ? MRECV : MIDLE;
`ifdef RDAT_M_TIMEOUT_EN
               to_d    = 1'b0;
`endif
            end
         end
         default: state_d = MDEFO;
      endcase

      if (w_setup) begin
         id_d  = rdata_m_exp_id;
         buf_d = '0;
         err_d = 1'b0;
         cnt_d = 2'd0;
`ifdef RDAT_M_TIMEOUT_EN
         stall_d = 16'd0;
         to_d    = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= MIDLE;
         buf_q   <= '0;
         id_q    <= '0;
         err_q   <= 1'b0;
         cnt_q   <= 2'd0;
`ifdef RDAT_M_TIMEOUT_EN
         stall_q <= 16'd0;
         to_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         id_q    <= id_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
`ifdef RDAT_M_TIMEOUT_EN
         stall_q <= stall_d;
         to_q    <= to_d;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rdata_chan_mngr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rdata_chan_mngr : directed scoreboard bench for rdata_chan_mngr.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_rdata_chan_mngr;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           rvalid = 1'b0;
   logic           rready;
   logic [3:0]     rid = '0;
   logic [31:0]    rdata = '0;
   logic           rlast = 1'b0;
   logic           rdata_m_start = 1'b0;
   logic [3:0]     rdata_m_exp_id = '0;
   logic           rdata_m_valid;
   logic [127:0]   rdata_m_data;
   logic [3:0]     rdata_m_id;
   logic           rdata_m_err;
   logic           rdata_m_ack = 1'b0;
   logic           rdata_m_busy;
`ifdef RDAT_M_TIMEOUT_EN
   logic           rdata_m_timeout;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [127:0] data;
      logic [3:0]   id;
      logic         err;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   rdata_chan_mngr #(.TO_CYCLES(16)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rvalid         (rvalid),
      .rready         (rready),
      .rid            (rid),
      .rdata          (rdata),
      .rlast          (rlast),
      .rdata_m_start  (rdata_m_start),
      .rdata_m_exp_id (rdata_m_exp_id),
      .rdata_m_valid  (rdata_m_valid),
      .rdata_m_data   (rdata_m_data),
      .rdata_m_id     (rdata_m_id),
      .rdata_m_err    (rdata_m_err),
      .rdata_m_ack    (rdata_m_ack),
      .rdata_m_busy   (rdata_m_busy)
`ifdef RDAT_M_TIMEOUT_EN
      ,
      .rdata_m_timeout(rdata_m_timeout)
`endif
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // All tasks are entered and left at a falling edge
   task automatic do_start(input logic [3:0] id);
      rdata_m_start  = 1'b1;
      rdata_m_exp_id = id;
      @(negedge clk);
      rdata_m_start  = 1'b0;
   endtask

   task automatic do_beat(input logic [31:0] d, input logic [3:0] id, input logic last);
      int k = 0;
      rvalid = 1'b1;
      rdata  = d;
      rid    = id;
      rlast  = last;
      while (rready !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("rready_wait", {127'd0, rready}, 128'd1);
      @(negedge clk);
      rvalid = 1'b0;
      rlast  = 1'b0;
   endtask

   task automatic do_ack();
      rdata_m_ack = 1'b1;
      @(negedge clk);
      rdata_m_ack = 1'b0;
   endtask

   task automatic expect_word();
      int k = 0;
      exp_t e;
      while (rdata_m_valid !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("valid_wait", {127'd0, rdata_m_valid}, 128'd1);
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $error("FAIL sb_underflow: observed word with empty scoreboard, data %0h", rdata_m_data);
      end else begin
         e = sb.pop_front();
         chk("word_data", rdata_m_data, e.data);
         chk("word_id",   {124'd0, rdata_m_id}, {124'd0, e.id});
         chk("word_err",  {127'd0, rdata_m_err}, {127'd0, e.err});
      end
   endtask

   task automatic chk_zero_outputs(input string pfx);
      chk({pfx, "_rready"}, {127'd0, rready}, 128'd0);
      chk({pfx, "_valid"},  {127'd0, rdata_m_valid}, 128'd0);
      chk({pfx, "_data"},   rdata_m_data, 128'd0);
      chk({pfx, "_id"},     {124'd0, rdata_m_id}, 128'd0);
      chk({pfx, "_err"},    {127'd0, rdata_m_err}, 128'd0);
      chk({pfx, "_busy"},   {127'd0, rdata_m_busy}, 128'd0);
   endtask

   initial begin
      logic [31:0] rd [4];
      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk_zero_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Nominal burst
      do_start(4'h5);
      chk("nom_busy",   {127'd0, rdata_m_busy}, 128'd1);
      chk("nom_rready", {127'd0, rready}, 128'd1);
      sb.push_back('{128'h44444444_33333333_22222222_11111111, 4'h5, 1'b0});
      do_beat(32'h11111111, 4'h5, 1'b0);
      do_beat(32'h22222222, 4'h5, 1'b0);
      do_beat(32'h33333333, 4'h5, 1'b0);
      do_beat(32'h44444444, 4'h5, 1'b1);
      chk("nom_valid_lat", {127'd0, rdata_m_valid}, 128'd1);
      expect_word();
      chk("nom_rready_full", {127'd0, rready}, 128'd0);
      do_ack();
      chk("nom_busy_after_ack", {127'd0, rdata_m_busy}, 128'd0);

      // Stalled burst, delayed ack; a start without ack in MFULL is ignored
      do_start(4'h5);
      sb.push_back('{128'h44444444_33333333_22222222_11111111, 4'h5, 1'b0});
      do_beat(32'h11111111, 4'h5, 1'b0);
      do_beat(32'h22222222, 4'h5, 1'b0);
      repeat (3) @(negedge clk);
      chk("stall_rready", {127'd0, rready}, 128'd1);
      do_beat(32'h33333333, 4'h5, 1'b0);
      do_beat(32'h44444444, 4'h5, 1'b1);
      expect_word();
      for (int i = 0; i < 5; i++) begin
         rdata_m_start  = (i == 2);
         rdata_m_exp_id = 4'h3;
         @(negedge clk);
         rdata_m_start  = 1'b0;
         chk("hold_valid", {127'd0, rdata_m_valid}, 128'd1);
         chk("hold_data",  rdata_m_data, 128'h44444444_33333333_22222222_11111111);
         chk("hold_id",    {124'd0, rdata_m_id}, 128'd5);
      end
      do_ack();

      // Early rlast on beat 1
      do_start(4'h5);
      sb.push_back('{{64'd0, 32'h0000000B, 32'h0000000A}, 4'h5, 1'b1});
      do_beat(32'h0000000A, 4'h5, 1'b0);
      do_beat(32'h0000000B, 4'h5, 1'b1);
      chk("early_valid", {127'd0, rdata_m_valid}, 128'd1);
      expect_word();
      @(negedge clk);
      chk("early_rready", {127'd0, rready}, 128'd0);
      do_ack();
      chk("idle_data_hold", rdata_m_data, {64'd0, 32'h0000000B, 32'h0000000A});

      // ID mismatch on beat 2 and missing rlast on beat 3
      do_start(4'h5);
      sb.push_back('{128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001, 4'h5, 1'b1});
      do_beat(32'hAAAA0001, 4'h5, 1'b0);
      do_beat(32'hBBBB0002, 4'h5, 1'b0);
      do_beat(32'hCCCC0003, 4'h6, 1'b0);
      do_beat(32'hDDDD0004, 4'h5, 1'b0);
      expect_word();

      // Ack + start overlap goes straight back to MRECV with cleared state
      rdata_m_ack    = 1'b1;
      rdata_m_start  = 1'b1;
      rdata_m_exp_id = 4'h9;
      @(negedge clk);
      rdata_m_ack    = 1'b0;
      rdata_m_start  = 1'b0;
      chk("ovl_rready", {127'd0, rready}, 128'd1);
      chk("ovl_valid",  {127'd0, rdata_m_valid}, 128'd0);
      chk("ovl_data",   rdata_m_data, 128'd0);
      chk("ovl_err",    {127'd0, rdata_m_err}, 128'd0);
      do_beat(32'h90000000, 4'h9, 1'b0);
      rdata_m_start  = 1'b1;
      rdata_m_exp_id = 4'h3;
      @(negedge clk);
      rdata_m_start  = 1'b0;
      chk("ign_rready", {127'd0, rready}, 128'd1);
      chk("ign_id",     {124'd0, rdata_m_id}, 128'd9);
      do_beat(32'h90000001, 4'h9, 1'b0);
      chk("ign_data", rdata_m_data, {64'd0, 32'h90000001, 32'h90000000});
      // Asynchronous reset in the middle of the burst
      #2 rst_n = 1'b0;
      #1 chk_zero_outputs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      rvalid = 1'b1;
      @(negedge clk);
      chk("idle_no_rready", {127'd0, rready}, 128'd0);
      rvalid = 1'b0;

      // Randomised data burst
      for (int i = 0; i < 4; i++) rd[i] = $urandom;
      do_start(4'hC);
      sb.push_back('{{rd[3], rd[2], rd[1], rd[0]}, 4'hC, 1'b0});
      for (int i = 0; i < 4; i++) do_beat(rd[i], 4'hC, (i == 3));
      expect_word();
      do_ack();

`ifdef RDAT_M_TIMEOUT_EN
      do_start(4'h2);
      repeat (15) @(negedge clk);
      chk("to_not_yet", {127'd0, rdata_m_valid}, 128'd0);
      @(negedge clk);
      chk("to_valid", {127'd0, rdata_m_valid}, 128'd1);
      chk("to_err",   {127'd0, rdata_m_err}, 128'd1);
      chk("to_flag",  {127'd0, rdata_m_timeout}, 128'd1);
      do_ack();
      chk("to_flag_clr", {127'd0, rdata_m_timeout}, 128'd0);
`endif

      chk("sb_drained", 128'(sb.size()), 128'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
